// File: rtl/vote_logger.sv
// vote_logger: front end of the EVM vote path. Debounces the four candidate
// buttons while in voting mode and accepts exactly one vote per press. It
// keeps a saturating tally for each candidate and emits a one-cycle
// valid_vote_casted pulse for every accepted vote.
module vote_logger #(
  parameter int CNT_W           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode,
  input  logic             cand1_button,
  input  logic             cand2_button,
  input  logic             cand3_button,
  input  logic             cand4_button,
  output logic [CNT_W-1:0] cand1_vote,
  output logic [CNT_W-1:0] cand2_vote,
  output logic [CNT_W-1:0] cand3_vote,
  output logic [CNT_W-1:0] cand4_vote,
  output logic             valid_vote_casted,
  output logic             busy,
  output logic             count_saturated
);

  localparam int DBC_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LKC_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [DBC_W-1:0] DBC_LAST  = DBC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LKC_W-1:0] LKC_LAST  = LKC_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    LOCKOUT,
    WAIT_RELEASE
  } state_t;

  state_t           state;
  logic [1:0]       cand_idx;
  logic [DBC_W-1:0] dbc;
  logic [LKC_W-1:0] lkc;
  logic [CNT_W-1:0] tally [4];

  logic [3:0] buttons;
  logic       lone;
  logic [1:0] press_idx;
  logic [3:0] latched_mask;

  assign buttons      = {cand4_button, cand3_button, cand2_button, cand1_button};
  assign lone         = (buttons != 4'd0) && ((buttons & (buttons - 4'd1)) == 4'd0);
  assign latched_mask = 4'd1 << cand_idx;

  // Encode the pressed button to a candidate index; only used when lone is high.
  always_comb begin
    // NOTE: default first so every path assigns press_idx and no latch is inferred.
    press_idx = 2'd0;
    case (buttons)
      4'b0010: press_idx = 2'd1;
      4'b0100: press_idx = 2'd2;
      4'b1000: press_idx = 2'd3;
      default: press_idx = 2'd0;
    endcase
  end

  // Vote FSM: debounce a lone press, commit the vote, lock out, wait for release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      cand_idx          <= 2'd0;
      dbc               <= '0;
      lkc               <= '0;
      valid_vote_casted <= 1'b0;
      busy              <= 1'b0;
      count_saturated   <= 1'b0;
      // NOTE: the tallies are four flops, not a RAM, so clearing them on reset is cheap and required.
      for (int i = 0; i < 4; i++) tally[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      valid_vote_casted <= 1'b0;
      case (state)
        IDLE: begin
          if (!mode && lone) begin
            state    <= DEBOUNCE;
            cand_idx <= press_idx;
            dbc      <= DBC_W'(1);
            busy     <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end

        DEBOUNCE: begin
          if (mode || (buttons != latched_mask)) begin
            state <= IDLE;
            dbc   <= '0;
            busy  <= 1'b0;
          end else if (dbc == DBC_LAST) begin
            if (tally[cand_idx] == CNT_MAX) count_saturated <= 1'b1;
            else                            tally[cand_idx] <= tally[cand_idx] + 1'b1;
            valid_vote_casted <= 1'b1;
            state             <= LOCKOUT;
            lkc               <= '0;
            dbc               <= '0;
          end else begin
            dbc <= dbc + 1'b1;
          end
        end

        LOCKOUT: begin
          if (lkc == LKC_LAST) begin
            state <= WAIT_RELEASE;
            lkc   <= '0;
          end else begin
            lkc <= lkc + 1'b1;
          end
        end

        WAIT_RELEASE: begin
          if (buttons == 4'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cand1_vote = tally[0];
  assign cand2_vote = tally[1];
  assign cand3_vote = tally[2];
  assign cand4_vote = tally[3];

endmodule

// File: tb/tb_vote_logger.sv
// tb_vote_logger: drives two vote_logger instances (8-bit and 2-bit tallies)
// with shared inputs and compares them every cycle against a behavioural
// model. Directed tables and sequences cover the latency, release and
// saturation corners.
module tb_vote_logger;

  localparam int DEB  = 4;
  localparam int LOCK = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       mode  = 1'b0;
  logic [3:0] btn   = 4'd0;

  logic [7:0] v1, v2, v3, v4;
  logic       valid, busy, sat;
  logic [1:0] s1, s2, s3, s4;
  logic       valid_s, busy_s, sat_s;

  always #5 clock = ~clock;

  vote_logger #(.CNT_W(8), .DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(LOCK)) dut (
    .clock(clock), .reset(reset), .mode(mode),
    .cand1_button(btn[0]), .cand2_button(btn[1]),
    .cand3_button(btn[2]), .cand4_button(btn[3]),
    .cand1_vote(v1), .cand2_vote(v2), .cand3_vote(v3), .cand4_vote(v4),
    .valid_vote_casted(valid), .busy(busy), .count_saturated(sat)
  );

  vote_logger #(.CNT_W(2), .DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(LOCK)) dut_sat (
    .clock(clock), .reset(reset), .mode(mode),
    .cand1_button(btn[0]), .cand2_button(btn[1]),
    .cand3_button(btn[2]), .cand4_button(btn[3]),
    .cand1_vote(s1), .cand2_vote(s2), .cand3_vote(s3), .cand4_vote(s4),
    .valid_vote_casted(valid_s), .busy(busy_s), .count_saturated(sat_s)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Behavioural model: a press "streak" counts consecutive qualifying samples;
  // after a vote, the voter is blocked for a fixed time and then until release.
  int m_cnt[4];
  int m_cnt_s[4];
  bit m_sat, m_sat_s;
  int streak, cand, lock_left;
  bit wait_rel;
  bit exp_valid, exp_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lone_idx(input logic [3:0] b);
    int n = 0;
    int idx = -1;
    for (int i = 0; i < 4; i++) if (b[i]) begin n++; idx = i; end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_cnt_s[i] = 0; end
    m_sat = 0; m_sat_s = 0;
    streak = 0; cand = 0; lock_left = 0; wait_rel = 0;
    exp_valid = 0; exp_busy = 0;
  endtask

  task automatic model_commit(input int c);
    exp_valid = 1;
    if (m_cnt[c] == 255) m_sat = 1; else m_cnt[c]++;
    if (m_cnt_s[c] == 3) m_sat_s = 1; else m_cnt_s[c]++;
  endtask

  task automatic model_step(input bit m, input logic [3:0] b);
    int idx;
    idx = lone_idx(b);
    exp_valid = 0;
    if (lock_left > 0) begin
      lock_left--;
      if (lock_left == 0) wait_rel = 1;
    end else if (wait_rel) begin
      if (b == 4'd0) wait_rel = 0;
    end else if (streak == 0) begin
      if (!m && idx >= 0) begin cand = idx; streak = 1; end
    end else if (m || idx != cand) begin
      streak = 0;
    end else if (streak == DEB - 1) begin
      model_commit(cand);
      streak = 0;
      lock_left = LOCK;
    end else begin
      streak++;
    end
    exp_busy = (streak > 0) || (lock_left > 0) || wait_rel;
  endtask

  task automatic compare_all();
    logic [31:0] a[4];
    logic [31:0] b[4];
    a[0] = 32'(v1); a[1] = 32'(v2); a[2] = 32'(v3); a[3] = 32'(v4);
    b[0] = 32'(s1); b[1] = 32'(s2); b[2] = 32'(s3); b[3] = 32'(s4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tally%0d", i + 1), a[i], 32'(m_cnt[i]));
      check($sformatf("sat_tally%0d", i + 1), b[i], 32'(m_cnt_s[i]));
    end
    check("valid", 32'(valid), 32'(exp_valid));
    check("busy", 32'(busy), 32'(exp_busy));
    check("count_saturated", 32'(sat), 32'(m_sat));
    check("sat_valid", 32'(valid_s), 32'(exp_valid));
    check("sat_busy", 32'(busy_s), 32'(exp_busy));
    check("sat_count_saturated", 32'(sat_s), 32'(m_sat_s));
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clock);
    if (!reset) model_clear();
    else        model_step(mode, btn);
    #1;
    if (valid) pulses++;
    compare_all();
  endtask

  task automatic hold(input bit m, input logic [3:0] b, input int n);
    mode = m;
    btn  = b;
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) tick();
    reset = 1'b1;
  endtask

  typedef struct {
    bit         mode;
    logic [3:0] btn;
    int         hold_cycles;
    int         gap_cycles;
    int         exp_pulses;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int base;
    model_clear();

    vecs[0] = '{1'b0, 4'b0010, 20, 16, 1};  // long lone press: one vote
    vecs[1] = '{1'b0, 4'b0001,  3, 16, 0};  // one sample short of debounce
    vecs[2] = '{1'b0, 4'b0101, 10, 16, 0};  // two buttons together
    vecs[3] = '{1'b1, 4'b0100, 10, 16, 0};  // result mode ignores presses
    vecs[4] = '{1'b0, 4'b0100,  4, 16, 1};  // exactly the debounce length
    vecs[5] = '{1'b0, 4'b1000, 30, 16, 1};  // held through lockout: still one vote
    vecs[6] = '{1'b0, 4'b1111,  8, 16, 0};  // all buttons
    vecs[7] = '{1'b0, 4'b0000,  8, 16, 0};  // nothing pressed

    // Reset for three cycles, then release.
    mode = 1'b0; btn = 4'd0;
    do_reset(3);
    check("rst_tally1", 32'(v1), 32'd0);
    check("rst_tally4", 32'(v4), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    tick();

    // Commit latency: pulse only after the fourth sampled edge, for one cycle.
    btn = 4'b0010;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check($sformatf("lat_valid_e%0d", e), 32'(valid), (e == DEB) ? 32'd1 : 32'd0);
      check($sformatf("lat_tally2_e%0d", e), 32'(v2), (e >= DEB) ? 32'd1 : 32'd0);
    end
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_tally1", 32'(v1), 32'd0);
    hold(1'b0, 4'd0, 16);

    // Table of single presses, each followed by an idle gap.
    for (int i = 0; i < 8; i++) begin
      pulses = 0;
      hold(vecs[i].mode, vecs[i].btn, vecs[i].hold_cycles);
      hold(1'b0, 4'd0, vecs[i].gap_cycles);
      check($sformatf("vec%0d_pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
    end

    // Long press, brief release, short press: exactly two votes.
    pulses = 0;
    base = m_cnt[3];
    hold(1'b0, 4'b1000, 30);
    hold(1'b0, 4'b0000, 2);
    hold(1'b0, 4'b1000, 5);
    hold(1'b0, 4'b0000, 16);
    check("repress_pulses", 32'(pulses), 32'd2);
    check("repress_tally4", 32'(v4), 32'(base + 2));

    // Reset asserted in the middle of debounce clears everything at once.
    hold(1'b0, 4'b0100, 2);
    check("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #2;
    model_clear();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tally2", 32'(v2), 32'd0);
    check("mid_rst_tally4", 32'(v4), 32'd0);
    check("mid_rst_sat_busy", 32'(busy_s), 32'd0);
    btn = 4'd0;
    tick();
    reset = 1'b1;
    tick();

    // Saturation on the 2-bit instance: five votes for candidate 1.
    pulses = 0;
    for (int k = 1; k <= 5; k++) begin
      hold(1'b0, 4'b0001, DEB);
      hold(1'b0, 4'b0000, 12);
      if (k == 3) check("sat3_flag", 32'(sat_s), 32'd0);
      if (k == 4) check("sat4_tally", 32'(s1), 32'd3);
    end
    check("sat_pulses", 32'(pulses), 32'd5);
    check("sat_tally1", 32'(s1), 32'd3);
    check("sat_flag", 32'(sat_s), 32'd1);
    check("sat_wide_tally1", 32'(v1), 32'd5);
    check("sat_wide_flag", 32'(sat), 32'd0);

    // Randomised segments, biased towards lone presses long enough to vote.
    for (int s = 0; s < 400; s++) begin
      int r;
      logic [3:0] b;
      r = $urandom_range(0, 9);
      if (r <= 5)      b = 4'd1 << $urandom_range(0, 3);
      else if (r == 6) b = (4'd1 << $urandom_range(0, 1)) | (4'd4 << $urandom_range(0, 1));
      else if (r == 7) b = 4'd0;
      else             b = 4'($urandom_range(0, 15));
      hold(($urandom_range(0, 7) == 0), b, $urandom_range(1, 8));
    end
    hold(1'b0, 4'd0, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
